// File: rtl/vga_pixel_renderer.sv
// Pixel pipeline for the snake grid: tracks line/cell position, fetches the cell code and drives RGB with matching syncs.
// Optional macro GRID_LINES_EN draws a dark grey grid on the top/left edge of empty cells.
module vga_pixel_renderer #(
    parameter int H_ACT_START = 144,
    parameter int V_ACT_START = 35,
    parameter int ACT_W       = 640,
    parameter int ACT_H       = 480,
    parameter int CELL_PX     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [19:0] hCount,
    input  logic        HS_in,
    input  logic        VS_in,
    output logic [9:0]  cell_addr,
    output logic        cell_rd,
    input  logic [1:0]  cell_data,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        HS,
    output logic        VS
);

    localparam logic [19:0] H_FIRST  = 20'(H_ACT_START);
    localparam logic [19:0] H_LAST   = 20'(H_ACT_START + ACT_W - 1);
    localparam logic [19:0] H_PRE    = 20'(H_ACT_START - 1);
    localparam logic [9:0]  V_FIRST  = 10'(V_ACT_START);
    localparam logic [9:0]  V_LAST   = 10'(V_ACT_START + ACT_H - 1);
    localparam logic [9:0]  V_PRE    = 10'(V_ACT_START - 1);
    localparam logic [4:0]  SUB_LAST = 5'(CELL_PX - 1);
    localparam logic [4:0]  COL_LAST = 5'(ACT_W / CELL_PX - 1);
    localparam logic [4:0]  ROW_LAST = 5'(ACT_H / CELL_PX - 1);

    logic [9:0]  r_line;
    logic        r_vs_prev;
    logic        r_frame_ok;
    logic        w_vs_fall;
    logic        w_line_start;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_act;
    logic [1:0]  w_clr;
    logic [1:0]  w_adv;
    logic [4:0]  w_col;
    logic [4:0]  w_row;

    logic        r_cell_rd;
    logic [9:0]  r_cell_addr;
    logic        r_s0_act;
    logic        r_s0_hs;
    logic        r_s0_vs;
    logic        r_cap;
    logic [1:0]  r_cell_q;
    logic [1:0]  w_code;
    logic [11:0] w_rgb;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;

    assign w_vs_fall    = r_vs_prev && !VS_in;
    assign w_line_start = (hCount == 20'd0);
    assign w_h_act      = (hCount >= H_FIRST) && (hCount <= H_LAST);
    assign w_v_act      = r_frame_ok && (r_line >= V_FIRST) && (r_line <= V_LAST);
    assign w_act        = w_h_act && w_v_act;

    // r_vs_prev resets low so only a genuine high-to-low VS transition after reset starts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line     <= 10'd0;
            r_vs_prev  <= 1'b0;
            r_frame_ok <= 1'b0;
        end else if (pix_en) begin
            r_vs_prev <= VS_in;
            if (w_vs_fall) begin
                r_line     <= 10'd0;
                r_frame_ok <= 1'b1;
            end else if (w_line_start && (r_line != 10'd1023)) begin
                r_line <= r_line + 10'd1;
            end
        end
    end

    // Axis 0 walks columns across a line, axis 1 walks rows down the frame.
    assign w_clr = {pix_en && (r_line == V_PRE),
                    pix_en && (hCount == H_PRE)};
    assign w_adv = {pix_en && w_line_start && (r_line >= V_FIRST) && (r_line <= V_LAST),
                    pix_en && w_h_act};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [4:0] IDX_LAST = (gi == 0) ? COL_LAST : ROW_LAST;
            logic [4:0] r_sub;
            logic [4:0] r_idx;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sub <= 5'd0;
                    r_idx <= 5'd0;
                end else if (w_clr[gi]) begin
                    r_sub <= 5'd0;
                    r_idx <= 5'd0;
                end else if (w_adv[gi]) begin
                    if (r_sub == SUB_LAST) begin
                        r_sub <= 5'd0;
                        if (r_idx != IDX_LAST) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end else begin
                        r_sub <= r_sub + 5'd1;
                    end
                end
            end
        end
    endgenerate

    assign w_col = g_axis[0].r_idx;
    assign w_row = g_axis[1].r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cell_rd   <= 1'b0;
            r_cell_addr <= 10'd0;
            r_s0_act    <= 1'b0;
            r_s0_hs     <= 1'b1;
            r_s0_vs     <= 1'b1;
        end else begin
            r_cell_rd <= pix_en && w_act;
            if (pix_en) begin
                r_s0_act <= w_act;
                r_s0_hs  <= HS_in;
                r_s0_vs  <= VS_in;
                if (w_act) begin
                    r_cell_addr <= {w_row, w_col};
                end
            end
        end
    end

    assign cell_rd   = r_cell_rd;
    assign cell_addr = r_cell_addr;

    // RAM registers the request on the edge after cell_rd; capture one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap    <= 1'b0;
            r_cell_q <= 2'd0;
        end else begin
            r_cap <= r_cell_rd;
            if (r_cap) begin
                r_cell_q <= cell_data;
            end
        end
    end

    assign w_code = r_cap ? cell_data : r_cell_q;

`ifdef GRID_LINES_EN
    logic r_s0_grid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_grid <= 1'b0;
        end else if (pix_en) begin
            r_s0_grid <= (g_axis[0].r_sub == 5'd0) || (g_axis[1].r_sub == 5'd0);
        end
    end
`endif

    always_comb begin
        w_rgb = 12'h000;
        if (r_s0_act) begin
            case (w_code)
                2'd1:    w_rgb = 12'h0F0;
                2'd2:    w_rgb = 12'hFF0;
                2'd3:    w_rgb = 12'hF00;
`ifdef GRID_LINES_EN
                default: w_rgb = r_s0_grid ? 12'h333 : 12'h000;
`else
                default: w_rgb = 12'h000;
`endif
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= 12'h000;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else if (pix_en) begin
            r_rgb <= w_rgb;
            r_hs  <= r_s0_hs;
            r_vs  <= r_s0_vs;
        end
    end

    assign R  = r_rgb[11:8];
    assign G  = r_rgb[7:4];
    assign B  = r_rgb[3:0];
    assign HS = r_hs;
    assign VS = r_vs;

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// Bench for vga_pixel_renderer: compressed frames with a per-pixel model, per-cycle compare, and literal pins.
module tb_vga_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [19:0] hCount;
    logic        HS_in;
    logic        VS_in;
    logic [9:0]  cell_addr;
    logic        cell_rd;
    logic [1:0]  cell_data;
    logic [3:0]  R;
    logic [3:0]  G;
    logic [3:0]  B;
    logic        HS;
    logic        VS;

    always #5 clk = ~clk;

    vga_pixel_renderer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hCount    (hCount),
        .HS_in     (HS_in),
        .VS_in     (VS_in),
        .cell_addr (cell_addr),
        .cell_rd   (cell_rd),
        .cell_data (cell_data),
        .R         (R),
        .G         (G),
        .B         (B),
        .HS        (HS),
        .VS        (VS)
    );

    // Game-state RAM with one-cycle synchronous read.
    logic [1:0] ram [1024];
    initial cell_data = 2'd0;
    always @(posedge clk) if (cell_rd) cell_data <= ram[cell_addr];

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_now;
    logic        exp_rd;
    logic [9:0]  exp_addr;
    bit          chk_en = 1'b0;
    bit          ok_m;
    bit          prev_vs_m;
    int          phase = 0;
    int          total = 0;
    int          bad = 0;
    int          rd_cnt[3];
    int          head_cnt[3];
    int          food_cnt[3];
    int          lit_cnt[3];
    int          sh[9] = '{0, 40, 95, 96, 143, 144, 145, 146, 790};

    function automatic bit in_active(input int h, input int v);
        return (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
    endfunction

    function automatic int cell_index(input int h, input int v);
        return ((v - 35) / 20) * 32 + (h - 144) / 20;
    endfunction

    function automatic logic [11:0] color_of(input int h, input int v);
        logic [1:0] code;
        if (!in_active(h, v)) return 12'h000;
        code = ram[cell_index(h, v)];
        case (code)
            2'd1:    return 12'h0F0;
            2'd2:    return 12'hFF0;
            2'd3:    return 12'hF00;
`ifdef GRID_LINES_EN
            default: return (((h - 144) % 20 == 0) || ((v - 35) % 20 == 0)) ? 12'h333 : 12'h000;
`else
            default: return 12'h000;
`endif
        endcase
    endfunction

    task automatic pin(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        e.rgb = 12'h000;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        exp_q.delete();
        exp_q.push_back(e);
        exp_now   = e;
        exp_rd    = 1'b0;
        exp_addr  = 10'd0;
        ok_m      = 1'b0;
        prev_vs_m = 1'b0;
    endtask

    task automatic pulse_reset(input int clks);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        repeat (clks) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // One pixel strobe followed by 3 (+extra) idle clocks.
    task automatic strobe(input int h, input int v, input int extra);
        exp_t e;
        bit   act;
        @(negedge clk);
        hCount = 20'(h);
        HS_in  = (h >= 96);
        VS_in  = (v >= 2);
        pix_en = 1'b1;
        if (prev_vs_m && !VS_in) ok_m = 1'b1;
        prev_vs_m = VS_in;
        act   = ok_m && in_active(h, v);
        e.rgb = act ? color_of(h, v) : 12'h000;
        e.hs  = HS_in;
        e.vs  = VS_in;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        while (exp_q.size() > 1) exp_now = exp_q.pop_front();
        exp_rd = act;
        if (act) exp_addr = 10'(cell_index(h, v));
        if ({R, G, B} == 12'hFF0) head_cnt[phase]++;
        if ({R, G, B} == 12'hF00) food_cnt[phase]++;
        if ({R, G, B} != 12'h000) lit_cnt[phase]++;
        @(negedge clk);
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        exp_rd = 1'b0;
        repeat (2 + extra) @(posedge clk);
    endtask

    task automatic run_line(input int v, input bit full, input int pause_h);
        if (full) begin
            for (int h = 0; h < 800; h++) strobe(h, v, (h == pause_h) ? 10 : 0);
        end else begin
            for (int i = 0; i < 9; i++) strobe(sh[i], v, 0);
        end
    endtask

    function automatic bit is_full(input int v);
        return (v == 35) || (v == 54) || (v == 55) || (v == 74) || (v == 75) || (v == 495) || (v == 514);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({R, G, B, HS, VS} !== {exp_now.rgb, exp_now.hs, exp_now.vs}) begin
                bad++;
                $display("FAIL out t=%0t got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                         $time, {R, G, B}, HS, VS, exp_now.rgb, exp_now.hs, exp_now.vs);
            end
            total++;
            if ((cell_rd !== exp_rd) || (exp_rd && (cell_addr !== exp_addr))) begin
                bad++;
                $display("FAIL rd t=%0t got rd=%b addr=%0d want rd=%b addr=%0d",
                         $time, cell_rd, cell_addr, exp_rd, exp_addr);
            end
            if (cell_rd === 1'b1) rd_cnt[phase]++;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 2'd0;
        ram[33]  = 2'd2;
        ram[767] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            rd_cnt[i] = 0; head_cnt[i] = 0; food_cnt[i] = 0; lit_cnt[i] = 0;
        end
        rst    = 1'b1;
        pix_en = 1'b0;
        hCount = 20'd0;
        HS_in  = 1'b1;
        VS_in  = 1'b1;
        model_reset();

        // Literal pins on the model itself.
        pin("model_head_first", int'(color_of(164, 55)), 'hFF0);
        pin("model_head_last",  int'(color_of(183, 74)), 'hFF0);
        pin("model_left_of_head", int'(color_of(163, 56)), 'h000);
        pin("model_right_of_head", int'(color_of(185, 74)), 'h000);
        pin("model_food_first", int'(color_of(764, 495)), 'hF00);
        pin("model_food_last",  int'(color_of(783, 514)), 'hF00);
        pin("model_above_food", int'(color_of(765, 494)), 'h000);
        pin("model_idx_food",   cell_index(783, 514), 767);

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #2;
        rst = 1'b0;

        // Tail of a frame with no VS seen since reset, plus a reset pulse mid-line.
        phase = 0;
        for (int v = 505; v < 525; v++) begin
            if (v == 510) begin
                for (int i = 0; i < 9; i++) begin
                    strobe(sh[i], v, 0);
                    if (i == 5) pulse_reset(3);
                end
            end else begin
                run_line(v, 1'b0, -1);
            end
        end

        phase = 1;
        for (int v = 0; v < 525; v++) run_line(v, is_full(v), (v == 55) ? 170 : -1);

        phase = 2;
        for (int v = 0; v < 37; v++) run_line(v, 1'b0, -1);
        repeat (4) @(posedge clk);

        pin("rd_before_vs",  rd_cnt[0], 0);
        pin("lit_before_vs", lit_cnt[0], 0);
        pin("head_pixels",   head_cnt[1], 40);
        pin("food_pixels",   food_cnt[1], 40);
        pin("rd_per_frame",  rd_cnt[1], 5899);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
